// File: rtl/riscv_ahb3_pkg.sv
// Shared AHB3-Lite encodings and the memory responder state type.
package riscv_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;
  localparam logic [2:0] HSIZE_B64 = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } resp_state_e;

endpackage

// File: rtl/riscv_ahb3_byte_enable.sv
// Byte-lane strobe from HSIZE and the low address bits; oversize transfers select every lane
// and misaligned low bits are rounded down to the transfer size.
module riscv_ahb3_byte_enable
  import riscv_ahb3_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  localparam int unsigned NB = XLEN / 8,
  localparam int unsigned AW = $clog2(NB)
) (
  input  logic [2:0]    hsize,
  input  logic [AW-1:0] addr_lo,
  output logic [NB-1:0] strb
);

  always_comb begin
    strb = '0;
    if (32'(hsize) >= AW) begin
      strb = '1;
    end else begin
      // A lane is enabled when it falls in the same size-aligned block as the address.
      for (int unsigned i = 0; i < NB; i++) begin
        if ((i >> hsize) == (32'(addr_lo) >> hsize)) begin
          strb[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_ahb3_mem_responder.sv
// AHB3-Lite slave memory with programmable wait states.
// Define RISCV_AHB3_MEM_ERR_EN to enable range/size/alignment checks and the ERROR response.
module riscv_ahb3_mem_responder
  import riscv_ahb3_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     PLEN        = 64,
  parameter int unsigned     MEM_DEPTH   = 1024,
  parameter logic [PLEN-1:0] BASE_ADDR   = '0,
  parameter int unsigned     WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            HSEL,
  input  logic [PLEN-1:0] HADDR,
  input  logic [XLEN-1:0] HWDATA,
  output logic [XLEN-1:0] HRDATA,
  input  logic            HWRITE,
  input  logic [2:0]      HSIZE,
  input  logic [2:0]      HBURST,
  input  logic [3:0]      HPROT,
  input  logic [1:0]      HTRANS,
  input  logic            HMASTLOCK,
  output logic            HREADY,
  output logic            HRESP
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned AW = $clog2(NB);
  localparam int unsigned IW = $clog2(MEM_DEPTH);
  localparam logic [PLEN-1:0] MEM_BYTES = PLEN'(MEM_DEPTH * NB);

  logic [XLEN-1:0] mem [MEM_DEPTH];

  resp_state_e   state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic          dphase_q, dphase_d;
  logic          write_q;
  logic [IW-1:0] addr_q;
  logic [NB-1:0] strb_q;

  logic            ready;
  logic            resp;
  logic            accept;
  logic            illegal;
  logic            commit;
  logic [PLEN-1:0] offset;
  logic [NB-1:0]   strb;
  logic            unused_ahb;

  assign offset = HADDR - BASE_ADDR;
  assign accept = HSEL & HTRANS[1] & ready;
  assign unused_ahb = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset, HADDR};

  riscv_ahb3_byte_enable #(
    .XLEN(XLEN)
  ) u_byte_enable (
    .hsize  (HSIZE),
    .addr_lo(HADDR[AW-1:0]),
    .strb   (strb)
  );

`ifdef RISCV_AHB3_MEM_ERR_EN
  logic range_err;
  logic size_err;
  logic align_err;

  // Addresses below BASE_ADDR wrap to a large offset and fail the same upper-bound test.
  assign range_err = offset >= MEM_BYTES;
  assign size_err  = 32'(HSIZE) > AW;

  always_comb begin
    align_err = 1'b0;
    for (int unsigned i = 0; i < AW; i++) begin
      if (i < 32'(HSIZE) && HADDR[i]) begin
        align_err = 1'b1;
      end
    end
  end

  assign illegal = range_err | size_err | align_err;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    ready = 1'b1;
    resp  = HRESP_OKAY;
    unique case (state_q)
      ST_WAIT: ready = 1'b0;
`ifdef RISCV_AHB3_MEM_ERR_EN
      ST_ERR1: begin
        ready = 1'b0;
        resp  = HRESP_ERROR;
      end
      ST_ERR2: resp = HRESP_ERROR;
`endif
      default: ;
    endcase
  end

  assign HREADY = ready;
  assign HRESP  = resp;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    dphase_d = dphase_q;
    unique case (state_q)
      ST_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q <= 4'd1) begin
          state_d = ST_IDLE;
        end
      end
`ifdef RISCV_AHB3_MEM_ERR_EN
      ST_ERR1: state_d = ST_ERR2;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Accepts only happen in ready states (ST_IDLE, ST_ERR2), so they override the above.
    if (accept && !illegal && WAIT_STATES != 0) begin
      state_d = ST_WAIT;
      wait_d  = 4'(WAIT_STATES);
    end
`ifdef RISCV_AHB3_MEM_ERR_EN
    if (accept && illegal) begin
      state_d = ST_ERR1;
    end
`endif

    if (ready) begin
      dphase_d = accept & ~illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      strb_q   <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      dphase_q <= dphase_d;
      if (accept) begin
        write_q <= HWRITE;
        addr_q  <= offset[AW +: IW];
        strb_q  <= strb;
      end
    end
  end

  // Errored phases never set dphase_q, so they cannot commit.
  assign commit = dphase_q & write_q & ready & ~rst;

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (strb_q[b]) begin
          mem[addr_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
        end
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (dphase_q && !write_q) begin
      HRDATA = mem[addr_q];
    end
  end

endmodule
